// File: rtl/mul_norm_round.sv
// Normalize-and-round back end of the FP32 multiplier: two valid/ready register
// stages that turn a 48-bit significand product into a packed IEEE-754 single.
module mul_norm_round #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 23
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sign,
  input  logic [SIZE_EXP-1:0]          i_exp_pre,
  input  logic                         i_exp_ovf,
  input  logic                         i_zero,
  input  logic [2*(SIZE_MAN+1)-1:0]    i_mant_prod,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SIZE_EXP+SIZE_MAN:0]   o_result,
  output logic                         o_ovf,
  output logic                         o_unf
);

  localparam int PW = 2 * (SIZE_MAN + 1);
  localparam logic [SIZE_EXP:0] EXP_MAX = {1'b0, {SIZE_EXP{1'b1}}};

  logic                  w_s2Load;
  logic                  w_s1Load;

  logic                  w_hi;
  logic [SIZE_MAN-1:0]   w_frac1;
  logic                  w_guard1;
  logic                  w_sticky1;
  logic [SIZE_EXP:0]     w_exp1;

  logic                  r_s1Valid;
  logic                  r_s1Sign;
  logic                  r_s1Zero;
  logic                  r_s1ExpOvf;
  logic                  r_s1UnfPre;
  logic [SIZE_MAN-1:0]   r_s1Frac;
  logic                  r_s1Guard;
  logic                  r_s1Sticky;
  logic [SIZE_EXP:0]     r_s1Exp;

  logic                  w_roundUp;
  logic [SIZE_MAN:0]     w_frac24;
  logic [SIZE_EXP:0]     w_exp2;
  logic [SIZE_MAN-1:0]   w_fracOut;
  logic [SIZE_EXP+SIZE_MAN:0] w_result;
  logic                  w_ovf;
  logic                  w_unf;

  logic                  r_oValid;
  logic [SIZE_EXP+SIZE_MAN:0] r_result;
  logic                  r_ovf;
  logic                  r_unf;

  assign w_s2Load = !r_oValid || i_ready;
  assign w_s1Load = !r_s1Valid || w_s2Load;
  assign o_ready  = w_s1Load;

  // Product is in [1,4): a set MSB means the binary point moves one place left.
  assign w_hi      = i_mant_prod[PW-1];
  assign w_frac1   = w_hi ? i_mant_prod[PW-2 -: SIZE_MAN] : i_mant_prod[PW-3 -: SIZE_MAN];
  assign w_guard1  = w_hi ? i_mant_prod[SIZE_MAN] : i_mant_prod[SIZE_MAN-1];
  assign w_sticky1 = w_hi ? (|i_mant_prod[SIZE_MAN-1:0]) : (|i_mant_prod[SIZE_MAN-2:0]);
  assign w_exp1    = {1'b0, i_exp_pre} + {{SIZE_EXP{1'b0}}, w_hi};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1Valid  <= 1'b0;
      r_s1Sign   <= 1'b0;
      r_s1Zero   <= 1'b0;
      r_s1ExpOvf <= 1'b0;
      r_s1UnfPre <= 1'b0;
      r_s1Frac   <= '0;
      r_s1Guard  <= 1'b0;
      r_s1Sticky <= 1'b0;
      r_s1Exp    <= '0;
    end else if (w_s1Load) begin
      r_s1Valid <= i_valid;
      if (i_valid) begin
        r_s1Sign   <= i_sign;
        r_s1Zero   <= i_zero;
        r_s1ExpOvf <= i_exp_ovf;
        r_s1UnfPre <= (i_exp_pre == '0);
        r_s1Frac   <= w_frac1;
        r_s1Guard  <= w_guard1;
        r_s1Sticky <= w_sticky1;
        r_s1Exp    <= w_exp1;
      end
    end
  end

  // Round to nearest, ties to even; a carry out of the fraction bumps the exponent.
  assign w_roundUp = r_s1Guard & (r_s1Sticky | r_s1Frac[0]);
  assign w_frac24  = {1'b0, r_s1Frac} + {{SIZE_MAN{1'b0}}, w_roundUp};
  assign w_exp2    = r_s1Exp + {{SIZE_EXP{1'b0}}, w_frac24[SIZE_MAN]};
  assign w_fracOut = w_frac24[SIZE_MAN] ? '0 : w_frac24[SIZE_MAN-1:0];

  always_comb begin
    w_result = {r_s1Sign, w_exp2[SIZE_EXP-1:0], w_fracOut};
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_s1Zero) begin
      w_result = {r_s1Sign, {(SIZE_EXP+SIZE_MAN){1'b0}}};
    end else if (r_s1ExpOvf || (w_exp2 >= EXP_MAX)) begin
      w_result = {r_s1Sign, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
      w_ovf    = 1'b1;
    end else if (r_s1UnfPre) begin
      // Flush to zero even if normalization/rounding would have lifted the exponent.
      w_result = {r_s1Sign, {(SIZE_EXP+SIZE_MAN){1'b0}}};
      w_unf    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oValid <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (w_s2Load) begin
      r_oValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_result <= w_result;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end
    end
  end

  assign o_valid  = r_oValid;
  assign o_result = r_result;
  assign o_ovf    = r_ovf;
  assign o_unf    = r_unf;

endmodule

// File: tb/tb_mul_norm_round.sv
// Self-checking bench for mul_norm_round: directed corner cases plus random
// traffic scored against an arithmetic reference model.
module tb_mul_norm_round;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp_pre;
  logic        i_exp_ovf;
  logic        i_zero;
  logic [47:0] i_mant_prod;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_ovf;
  logic        o_unf;

  int checks = 0;
  int errors = 0;
  int outCount = 0;
  logic [33:0] expQ[$];
  logic        stallPrev = 1'b0;
  logic [33:0] held = '0;

  mul_norm_round #(.SIZE_EXP(8), .SIZE_MAN(23)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp_pre(i_exp_pre), .i_exp_ovf(i_exp_ovf),
    .i_zero(i_zero), .i_mant_prod(i_mant_prod), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value-level normalize, round-half-even on the discarded remainder,
  // then the special-case priority. Returns {ovf, unf, result}.
  function automatic logic [33:0] model(input logic s, input logic [7:0] ep,
                                        input logic eo, input logic z,
                                        input logic [47:0] prod);
    longint unsigned p, m, rem, half;
    int sh, e;
    p  = 64'(prod);
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = int'(ep) + (sh - 23);
    m  = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
    if (m >= (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (z) return {2'b00, s, 31'b0};
    if (eo || e >= 255) return {2'b10, s, 8'hFF, 23'b0};
    if (ep == 0) return {2'b01, s, 31'b0};
    return {2'b00, s, 8'(e), 23'(m)};
  endfunction

  // Scoreboard / stability monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [33:0] expected;
    if (!rst_n) begin
      expQ.delete();
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checks++;
        assert (o_valid === 1'b1 && {o_ovf, o_unf, o_result} === held)
        else begin
          errors++;
          $error("FAIL hold_stable observed v=%b %h required v=1 %h", o_valid, {o_ovf, o_unf, o_result}, held);
        end
      end
      if (o_valid && i_ready) begin
        checks++;
        assert (expQ.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_output observed=%h required=no beat", o_result);
        end
        if (expQ.size() != 0) begin
          expected = expQ.pop_front();
          checks++;
          assert ({o_ovf, o_unf, o_result} === expected)
          else begin
            errors++;
            $error("FAIL scoreboard observed=%h required=%h", {o_ovf, o_unf, o_result}, expected);
          end
          outCount++;
        end
      end
      if (i_valid && o_ready)
        expQ.push_back(model(i_sign, i_exp_pre, i_exp_ovf, i_zero, i_mant_prod));
      stallPrev = o_valid && !i_ready;
      held = {o_ovf, o_unf, o_result};
    end
  end

  task automatic randBeat();
    logic [47:0] a, b;
    a = 48'($urandom_range(0, 24'hFFFFFF) | 32'h0080_0000);
    b = 48'($urandom_range(0, 24'hFFFFFF) | 32'h0080_0000);
    i_mant_prod = a * b;
    i_sign      = 1'($urandom);
    i_exp_pre   = 8'($urandom);
    i_exp_ovf   = ($urandom % 16) == 0;
    i_zero      = ($urandom % 16) == 0;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] ep, input logic eo,
                               input logic z, input logic [47:0] p);
    @(posedge clk); #1;
    i_valid = 1'b1; i_ready = 1'b1;
    i_sign = s; i_exp_pre = ep; i_exp_ovf = eo; i_zero = z; i_mant_prod = p;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expRes,
                             input logic expOvf, input logic expUnf);
    checks++;
    assert (o_valid === 1'b1 && o_result === expRes && o_ovf === expOvf && o_unf === expUnf)
    else begin
      errors++;
      $error("FAIL %s observed v=%b res=%h ovf=%b unf=%b required v=1 res=%h ovf=%b unf=%b",
             tag, o_valid, o_result, o_ovf, o_unf, expRes, expOvf, expUnf);
    end
  endtask

  // One beat on an idle pipe; result must appear exactly two cycles later.
  task automatic runDirected(input string tag, input logic s, input logic [7:0] ep,
                             input logic eo, input logic z, input logic [47:0] p,
                             input logic [31:0] expRes, input logic expOvf, input logic expUnf);
    applyStimulus(s, ep, eo, z, p);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    assert (o_valid === 1'b0)
    else begin
      errors++;
      $error("FAIL %s_early observed o_valid=%b required=0", tag, o_valid);
    end
    @(negedge clk);
    checkOutput(tag, expRes, expOvf, expUnf);
  endtask

  initial begin
    int sent, outBase, drainCnt;
    logic sawLow, pending;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_sign = 1'b0; i_exp_pre = '0; i_exp_ovf = 1'b0; i_zero = 1'b0; i_mant_prod = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (o_valid === 1'b0 && o_result === 32'h0 && o_ovf === 1'b0 && o_unf === 1'b0)
    else begin
      errors++;
      $error("FAIL reset_state observed v=%b res=%h ovf=%b unf=%b required all 0", o_valid, o_result, o_ovf, o_unf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    assert (o_ready === 1'b1)
    else begin
      errors++;
      $error("FAIL reset_ready observed=%b required=1", o_ready);
    end

    $display("[TB] directed cases");
    runDirected("mul_1p5", 1'b0, 8'd127, 1'b0, 1'b0, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
    runDirected("round_carry", 1'b0, 8'd127, 1'b0, 1'b0, 48'h7FFFFFC00000, 32'h40000000, 1'b0, 1'b0);
    runDirected("tie_even", 1'b0, 8'd127, 1'b0, 1'b0, 48'h7FFFFF400000, 32'h3FFFFFFE, 1'b0, 1'b0);
    runDirected("ovf_exp254", 1'b0, 8'd254, 1'b0, 1'b0, 48'h800000000000, 32'h7F800000, 1'b1, 1'b0);
    runDirected("ovf_flag_neg", 1'b1, 8'd10, 1'b1, 1'b0, 48'h400000000000, 32'hFF800000, 1'b1, 1'b0);
    runDirected("unf_exp0", 1'b0, 8'd0, 1'b0, 1'b0, 48'h800000000000, 32'h00000000, 1'b0, 1'b1);
    runDirected("zero_over_ovf", 1'b1, 8'd200, 1'b1, 1'b1, 48'h900000000000, 32'h80000000, 1'b0, 1'b0);

    $display("[TB] backpressure stream");
    sent = 0; outBase = outCount; sawLow = 1'b0; pending = 1'b0;
    for (int c = 0; c < 40 && (outCount - outBase) < 5; c++) begin
      @(posedge clk); #1;
      i_ready = !(c >= 3 && c <= 5);
      if (sent < 5) begin
        if (!pending) randBeat();
        i_valid = 1'b1;
        pending = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      if (!o_ready) sawLow = 1'b1;
      if (i_valid && o_ready) begin
        sent++;
        pending = 1'b0;
      end
      #1;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    checks++;
    assert (sawLow === 1'b1)
    else begin
      errors++;
      $error("FAIL bp_ready_drop observed=%b required=1", sawLow);
    end
    checks++;
    assert (outCount - outBase == 5 && sent == 5)
    else begin
      errors++;
      $error("FAIL bp_count observed out=%0d sent=%0d required 5/5", outCount - outBase, sent);
    end

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b0, 8'd100, 1'b0, 1'b0, 48'h900000000000);
    applyStimulus(1'b1, 8'd120, 1'b0, 1'b0, 48'hA00000000000);
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (o_valid === 1'b0 && o_result === 32'h0 && o_ovf === 1'b0 && o_unf === 1'b0)
    else begin
      errors++;
      $error("FAIL midreset_clear observed v=%b res=%h ovf=%b unf=%b required all 0", o_valid, o_result, o_ovf, o_unf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    assert (o_ready === 1'b1 && o_valid === 1'b0)
    else begin
      errors++;
      $error("FAIL midreset_release observed rdy=%b v=%b required rdy=1 v=0", o_ready, o_valid);
    end
    outBase = outCount;
    runDirected("post_reset", 1'b0, 8'd127, 1'b0, 1'b0, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    assert (outCount - outBase == 1)
    else begin
      errors++;
      $error("FAIL no_stale observed outputs=%0d required=1", outCount - outBase);
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!(i_valid && !o_ready)) begin
        i_valid = ($urandom % 4) != 0;
        randBeat();
      end
      i_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    drainCnt = 0;
    while (expQ.size() != 0 && drainCnt < 20) begin
      @(posedge clk); #1;
      drainCnt++;
    end
    checks++;
    assert (expQ.size() == 0)
    else begin
      errors++;
      $error("FAIL drain observed pending=%0d required=0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_norm_round.md
# mul_norm_round

Pipelined normalize-and-round stage of the FP32 multiplier, directly downstream of the multiplier exponent unit and the 24x24 mantissa multiplier. Takes the biased, clamped pre-exponent, the 48-bit significand product and operand flags, then normalizes, rounds to nearest-even and packs an IEEE-754 single result. Two register stages with valid/ready flow control, so the FPU_MUL path can be stalled by the FFT butterfly datapath it feeds.

## Interface
- SIZE_EXP, 8, exponent width.
- SIZE_MAN, 23, stored fraction width; product width is 2*(SIZE_MAN+1) = 48.
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  stage can accept a beat this cycle.
- i_sign  in  1  result sign (sign_a XOR sign_b).
- i_exp_pre  in  SIZE_EXP  biased pre-exponent exp_a+exp_b-127, clamped to 0 when negative.
- i_exp_ovf  in  1  exp_a+exp_b-127 >= 256; the clamped pre-exponent has lost this bit.
- i_zero  in  1  at least one operand is zero.
- i_mant_prod  in  48  unsigned product of the two 24-bit significands (hidden bit included).
- o_valid  out  1  o_result valid.
- i_ready  in  1  downstream accepts.
- o_result  out  32  packed {sign, exp, fraction}.
- o_ovf  out  1  result saturated to infinity.
- o_unf  out  1  result flushed to zero.

## Operation
- Stage 1 (normalize), registered into s1:
  - Product lies in [1,4). If p[47]=1: frac=p[46:24], guard=p[23], sticky=|p[22:0], exp9={0,i_exp_pre}+1.
  - Else: frac=p[45:23], guard=p[22], sticky=|p[21:0], exp9={0,i_exp_pre}.
  - Carry sign, i_zero, i_exp_ovf, and unf_pre=(i_exp_pre==0).
- Stage 2 (round/pack), registered into output regs:
  - round_up = guard & (sticky | frac[0]). frac24 = {0,frac} + round_up.
  - If frac24[23] (carry out): frac=0, exp9=exp9+1.
- Priority of special cases, highest first:
  - i_zero: o_result={sign,31'b0}, no flags.
  - i_exp_ovf or exp9>=255: o_result={sign,8'hFF,23'b0}, o_ovf=1.
  - unf_pre: o_result={sign,31'b0}, o_unf=1. Flush-to-zero policy: no denormals, even if normalization or rounding would lift the exponent to 1.
  - Otherwise: o_result={sign,exp9[7:0],frac}.
- NaN/Inf operands are handled upstream; this stage never emits a NaN.
- All exponent arithmetic is 9 bits wide, so no internal wrap.

## Timing
- Latency: 2 cycles from accepted input (i_valid&o_ready) to o_valid, with no stalls.
- Throughput: 1 beat/cycle while i_ready=1.
- Pipeline rules:
  - s2 loads when !o_valid | i_ready.
  - s1 loads when !s1_valid | (s2 loads).
  - o_ready = !s1_valid | (s2 loads).
  - o_ready depends combinationally on i_ready; no other comb input-to-output paths.
- While o_valid=1 and i_ready=0, o_result, o_ovf and o_unf stay stable. No beat is dropped or duplicated.
- A beat accepted in the same cycle another leaves advances normally (full stage refill).
- Reset (asynchronous, any cycle including mid-stall):
  - s1_valid=0, o_valid=0, o_result=0, o_ovf=0, o_unf=0.
  - o_ready=1 from the first cycle after release.
  - In-flight beats are discarded.

## Test plan
- 1.5*1.5: i_exp_pre=127, p=48'h900000000000, i_sign=0 -> o_result=32'h40100000 at cycle +2, no flags.
- Round carry: i_exp_pre=127, p=48'h7FFFFFC00000 (tie, frac odd) -> round up, carry, o_result=32'h40000000. Tie with even frac, p=48'h7FFFFF400000 -> o_result=32'h3FFFFFFE (no round up).
- Overflow and underflow:
  - i_exp_pre=254, p[47]=1 -> o_result=32'h7F800000, o_ovf=1.
  - i_exp_ovf=1, i_sign=1 -> 32'hFF800000, o_ovf=1.
  - i_exp_pre=0 -> 32'h00000000, o_unf=1.
  - i_zero=1 together with i_exp_ovf=1 -> signed zero, no flags.
- Backpressure: stream 5 beats back-to-back with i_ready low for cycles 3-5. Required: o_ready drops once both stages are full, output holds stable, all 5 results appear in order exactly once.
- Reset mid-stream: assert i_rst_n=0 with 2 beats in flight -> o_valid=0 and outputs 0 immediately. After release, the first new beat appears 2 cycles after acceptance and no stale beats emerge.
